// File: rtl/mem_responder.sv
// Memory-side responder for the read/write request/response protocol: a word-organised
// single-port RAM with a fixed accept-to-done latency, byte/half/word masks and bad-access reporting.
module mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [36:0] rd_req,    // {addr[31:0], mask[3:0], en}
  input  logic [68:0] wr_req,    // {addr[31:0], data[31:0], mask[3:0], en}
  output logic [65:0] rd_rsp,    // {addr[31:0], data[31:0], valid, done}
  output logic [1:0]  wr_rsp,    // {valid, done}
  output logic        busy,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [3:0] BYTE_MASK = 4'b0001;
  localparam logic [3:0] HALF_MASK = 4'b0011;
  localparam logic [3:0] WORD_MASK = 4'b1111;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t        state, state_next;
  logic          accept, finish;
  logic [CW-1:0] count;
  logic [31:0]   cap_addr, cap_data;
  logic [3:0]    cap_mask;
  logic          cap_write;
  logic [31:0]   ram [DEPTH_WORDS];

  logic        rd_en, wr_en;
  logic [3:0]  rd_mask, wr_mask;
  logic [31:0] rd_addr, wr_addr, wr_data;

  assign rd_en   = rd_req[0];
  assign rd_mask = rd_req[4:1];
  assign rd_addr = rd_req[36:5];
  assign wr_en   = wr_req[0];
  assign wr_mask = wr_req[4:1];
  assign wr_data = wr_req[36:5];
  assign wr_addr = wr_req[68:37];

  // Handshake: a request is taken on the edge where state is IDLE and its en is high;
  // the matching done pulses for exactly one cycle while in DONE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (rd_en || wr_en) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_next = DONE;
            finish     = 1'b1;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (count == '0) begin
          state_next = DONE;
          finish     = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // With LATENCY=1 the access completes on the accept edge, so operands come from the live inputs.
  logic          op_write;
  logic [31:0]   op_addr, op_data, rel, word, rd_data, wr_word, rd_shift, wr_shift, byte_en;
  logic [3:0]    op_mask;
  logic [1:0]    off;
  logic [7:0]    lanes_wide;
  logic [AW-1:0] w;
  logic          ok;

  always_comb begin
    op_write   = (state == IDLE) ? wr_en : cap_write;
    op_addr    = (state == IDLE) ? (wr_en ? wr_addr : rd_addr) : cap_addr;
    op_mask    = (state == IDLE) ? (wr_en ? wr_mask : rd_mask) : cap_mask;
    op_data    = (state == IDLE) ? wr_data : cap_data;
    rel        = op_addr - BASE_ADDR;
    off        = rel[1:0];
    lanes_wide = {4'b0000, op_mask} << off;
    ok = ((op_mask == BYTE_MASK) || (op_mask == HALF_MASK) || (op_mask == WORD_MASK)) &&
         (lanes_wide[7:4] == 4'b0000) &&
         (op_addr >= BASE_ADDR) && ((rel >> 2) < 32'(DEPTH_WORDS));
    w        = rel[AW+1:2];
    word     = ram[w];
    rd_shift = word >> {off, 3'b000};
    byte_en  = {{8{op_mask[3]}}, {8{op_mask[2]}}, {8{op_mask[1]}}, {8{op_mask[0]}}};
    rd_data  = rd_shift & byte_en;
    wr_shift = op_data << {off, 3'b000};
    wr_word  = word;
    for (int i = 0; i < 4; i++) begin
      if (lanes_wide[i]) wr_word[8*i +: 8] = wr_shift[8*i +: 8];
    end
  end

  logic        rd_done_q, rd_valid_q, wr_done_q, wr_valid_q;
  logic [31:0] rd_data_q, rd_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      cap_addr   <= '0;
      cap_data   <= '0;
      cap_mask   <= '0;
      cap_write  <= 1'b0;
      rd_done_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_addr_q  <= '0;
      wr_done_q  <= 1'b0;
      wr_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        cap_write <= wr_en;
        cap_addr  <= wr_en ? wr_addr : rd_addr;
        cap_mask  <= wr_en ? wr_mask : rd_mask;
        cap_data  <= wr_data;
        count     <= CW'(LATENCY - 1);
      end else if (state == BUSY && count != '0) begin
        count <= count - 1'b1;
      end
      if (finish) begin
        if (op_write) begin
          wr_done_q  <= 1'b1;
          wr_valid_q <= ok;
        end else begin
          rd_done_q  <= 1'b1;
          rd_valid_q <= ok;
          rd_data_q  <= ok ? rd_data : '0;
          rd_addr_q  <= op_addr;
        end
      end else if (state == DONE) begin
        rd_done_q  <= 1'b0;
        rd_valid_q <= 1'b0;
        rd_data_q  <= '0;
        rd_addr_q  <= '0;
        wr_done_q  <= 1'b0;
        wr_valid_q <= 1'b0;
      end
    end
  end

  // The array is never reset; a reset held across the completing edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && finish && op_write && ok) ram[w] <= wr_word;
  end

  assign rd_rsp    = {rd_addr_q, rd_data_q, rd_valid_q, rd_done_q};
  assign wr_rsp    = {wr_valid_q, wr_done_q};
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: randomized and directed traffic on a LATENCY=2 instance,
// plus directed reset-abort (LATENCY=3) and back-to-back (LATENCY=1) scenarios.
module tb_mem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst3;
  logic [36:0] rd_req1, rd_req2, rd_req3;
  logic [68:0] wr_req1, wr_req2, wr_req3;
  logic [65:0] rd_rsp1, rd_rsp2, rd_rsp3;
  logic [1:0]  wr_rsp1, wr_rsp2, wr_rsp3;
  logic        busy1, busy2, busy3;
  logic [1:0]  st1, st2, st3;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) u_dut2 (
    .clk(clk), .rst(rst), .rd_req(rd_req2), .wr_req(wr_req2),
    .rd_rsp(rd_rsp2), .wr_rsp(wr_rsp2), .busy(busy2), .state_dbg(st2));
  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .BASE_ADDR(BASE)) u_dut3 (
    .clk(clk), .rst(rst3), .rd_req(rd_req3), .wr_req(wr_req3),
    .rd_rsp(rd_rsp3), .wr_rsp(wr_rsp3), .busy(busy3), .state_dbg(st3));
  mem_responder #(.DEPTH_WORDS(16), .LATENCY(1), .BASE_ADDR(BASE)) u_dut1 (
    .clk(clk), .rst(rst), .rd_req(rd_req1), .wr_req(wr_req1),
    .rd_rsp(rd_rsp1), .wr_rsp(wr_rsp1), .busy(busy1), .state_dbg(st1));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed view of the first 16 words, rules applied byte by byte.
  logic [31:0] model_mem [16];
  logic [65:0] exp_q [$];   // {is_write, valid, rd_data, rd_addr}
  int          acc_q [$];

  function automatic logic [65:0] model(input bit wr, input logic [31:0] addr,
                                        input logic [31:0] data, input logic [3:0] mask);
    int unsigned off = addr % 4;
    bit          ok;
    logic [31:0] rdata = 32'h0;
    int unsigned widx;
    ok = (mask == 4'h1) || (mask == 4'h3) || (mask == 4'hF);
    for (int i = 0; i < 4; i++) if (mask[i] && (i + off > 3)) ok = 1'b0;
    if (addr < BASE || ((addr - BASE) / 4) >= DEPTH) ok = 1'b0;
    if (ok) begin
      widx = (addr - BASE) / 4;
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          if (wr) model_mem[widx][8*(i+off) +: 8] = data[8*i +: 8];
          else    rdata[8*i +: 8] = model_mem[widx][8*(i+off) +: 8];
        end
      end
    end
    return {wr, ok, rdata, wr ? 32'h0 : addr};
  endfunction

  logic [65:0] mon_e;
  int          mon_a;
  always @(negedge clk) begin
    if (!rst && (rd_rsp2[0] || wr_rsp2[0])) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done with nothing outstanding, expected no done");
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = acc_q.pop_front();
        chk("latency", 64'(cyc - mon_a), 64'd2);
        chk("busy_in_done", busy2, 1'b1);
        if (mon_e[65]) begin
          chk("wr_done", wr_rsp2[0], 1'b1);
          chk("rd_done_quiet", rd_rsp2[0], 1'b0);
          chk("wr_valid", wr_rsp2[1], mon_e[64]);
        end else begin
          chk("rd_done", rd_rsp2[0], 1'b1);
          chk("wr_done_quiet", wr_rsp2[0], 1'b0);
          chk("rd_valid", rd_rsp2[1], mon_e[64]);
          chk("rd_data", rd_rsp2[33:2], mon_e[63:32]);
          chk("rd_addr", rd_rsp2[65:34], mon_e[31:0]);
        end
      end
    end
  end

  task automatic wait_idle2();
    int t = 0;
    @(negedge clk);
    while (busy2 && t < 50) begin @(negedge clk); t++; end
    if (busy2) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: busy=1 after 50 cycles, expected 0");
    end
  endtask

  task automatic send(input bit w, input bit r, input logic [31:0] waddr, input logic [31:0] wdata,
                      input logic [3:0] wmask, input logic [31:0] raddr, input logic [3:0] rmask);
    int t = 0;
    wait_idle2();
    wr_req2 = w ? {waddr, wdata, wmask, 1'b1} : '0;
    rd_req2 = r ? {raddr, rmask, 1'b1} : '0;
    if (w) exp_q.push_back(model(1'b1, waddr, wdata, wmask));
    if (r) exp_q.push_back(model(1'b0, raddr, 32'h0, rmask));
    @(posedge clk);
    #1 acc_q.push_back(cyc);
    @(negedge clk);
    wr_req2 = '0;
    if (w && r) begin
      while (busy2 && t < 50) begin @(negedge clk); t++; end
      @(posedge clk);
      #1 acc_q.push_back(cyc);
      @(negedge clk);
    end
    rd_req2 = '0;
  endtask

  task automatic op3(input bit w, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] mask, output int lat, output logic [65:0] rr,
                     output logic [1:0] wr);
    int a;
    lat = -1;
    rr  = '0;
    wr  = '0;
    @(negedge clk);
    if (w) wr_req3 = {addr, data, mask, 1'b1};
    else   rd_req3 = {addr, mask, 1'b1};
    @(posedge clk);
    #1 a = cyc;
    @(negedge clk);
    wr_req3 = '0;
    rd_req3 = '0;
    for (int t = 0; t < 10; t++) begin
      if (rd_rsp3[0] || wr_rsp3[0]) begin
        lat = cyc - a;
        rr  = rd_rsp3;
        wr  = wr_rsp3;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  mask_tab [7];
    logic [31:0] a0, a1, d0;
    logic [3:0]  m0, m1;
    int          lat, nd, last, k;
    logic [65:0] rr;
    logic [1:0]  wr;

    mask_tab = '{4'h1, 4'h3, 4'hF, 4'h1, 4'h3, 4'hF, 4'h0};
    rst = 1'b1; rst3 = 1'b1;
    rd_req1 = '0; rd_req2 = '0; rd_req3 = '0;
    wr_req1 = '0; wr_req2 = '0; wr_req3 = '0;
    repeat (3) @(negedge clk);
    chk("rst_rd_rsp2", rd_rsp2, 66'h0);
    chk("rst_wr_rsp2", wr_rsp2, 2'b00);
    chk("rst_busy2", busy2, 1'b0);
    chk("rst_rd_rsp3", rd_rsp3, 66'h0);
    chk("rst_busy1", busy1, 1'b0);
    rst = 1'b0; rst3 = 1'b0;

    // Fill the modelled window so every later read has a known value.
    for (int i = 0; i < 16; i++) send(1'b1, 1'b0, 32'(i * 4), $urandom, 4'hF, 32'h0, 4'h0);

    send(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 4'h0);
    send(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h10, 4'hF);
    send(1'b1, 1'b0, 32'h13, 32'h000000AA, 4'h1, 32'h0, 4'h0);
    send(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h10, 4'hF);
    send(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h13, 4'h1);
    send(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h13, 4'h3);
    send(1'b1, 1'b0, 32'h12, 32'h55555555, 4'hF, 32'h0, 4'h0);
    send(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h10, 4'hF);
    send(1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF, 32'h20, 4'hF);
    send(1'b1, 1'b0, 32'(DEPTH * 4) + BASE, 32'hFFFFFFFF, 4'h5, 32'h0, 4'h0);
    send(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h0, 4'hF);
    send(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h10, 4'hF);

    for (int n = 0; n < 80; n++) begin
      a0 = ($urandom_range(0, 99) < 85) ? 32'($urandom_range(0, 63)) : 32'(DEPTH * 4) + $urandom_range(0, 255);
      a1 = ($urandom_range(0, 99) < 85) ? 32'($urandom_range(0, 63)) : 32'hFFFFFFF0 | $urandom_range(0, 15);
      m0 = mask_tab[$urandom_range(0, 6)];
      m1 = mask_tab[$urandom_range(0, 6)];
      if (m0 == 4'h0) m0 = 4'($urandom);
      d0 = $urandom;
      k  = $urandom_range(0, 7);
      send(k < 4 || k == 7, k >= 4, a0, d0, m0, a1, m1);
    end

    begin
      int t = 0;
      while (exp_q.size() != 0 && t < 100) begin @(negedge clk); t++; end
      chk("drain_outstanding", exp_q.size(), 0);
    end

    // Reset during BUSY aborts a pending write on the LATENCY=3 instance.
    op3(1'b1, 32'h30, 32'h11223344, 4'hF, lat, rr, wr);
    chk("l3_wr_latency", lat, 3);
    chk("l3_wr_rsp", wr, 2'b11);
    @(negedge clk);
    wr_req3 = {32'h30, 32'hCAFEF00D, 4'hF, 1'b1};
    @(posedge clk);
    @(negedge clk);
    wr_req3 = '0;
    @(posedge clk);
    #1 rst3 = 1'b1;
    #1;
    chk("abort_busy", busy3, 1'b0);
    chk("abort_wr_rsp", wr_rsp3, 2'b00);
    chk("abort_state", st3, 2'd0);
    @(posedge clk);
    #1 rst3 = 1'b0;
    nd = 0;
    repeat (8) begin @(negedge clk); nd += int'(wr_rsp3[0] | rd_rsp3[0]); end
    chk("abort_no_done", nd, 0);
    op3(1'b0, 32'h30, 32'h0, 4'hF, lat, rr, wr);
    chk("l3_rd_latency", lat, 3);
    chk("l3_rd_valid", rr[1], 1'b1);
    chk("l3_rd_old_data", rr[33:2], 32'h11223344);

    // LATENCY=1 with en held: one done every second cycle.
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      if (p == 0) wr_req1 = {32'h8, 32'hA5A55A5A, 4'hF, 1'b1};
      else        rd_req1 = {32'h8, 4'hF, 1'b1};
      nd = 0;
      last = -1;
      repeat (12) begin
        @(negedge clk);
        if (wr_rsp1[0] || rd_rsp1[0]) begin
          nd++;
          if (last >= 0) chk("l1_done_gap", cyc - last, 2);
          last = cyc;
          if (p == 1) chk("l1_rd_data", rd_rsp1[33:2], 32'hA5A55A5A);
          else        chk("l1_wr_valid", wr_rsp1[1], 1'b1);
        end
      end
      wr_req1 = '0;
      rd_req1 = '0;
      chk("l1_done_count", nd, 6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
